npc_ctrl: RTL and testbench
===========================

# npc_ctrl

Next-PC sequencer for the fetch stage. It arbitrates redirect sources (exception, eret, branch/jump) against sequential fetch and drives `next_pc` and `stall` into the PC register. A redirect that arrives while fetch is stalled is buffered, so it is never lost, and is applied on the first unstalled cycle. The block also emits a one-cycle squash pulse to the fetch pipeline.

## Interface
Parameters:
- `EXC_VECTOR`, default `32'hbfc0_0380`: general exception entry address.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `pc`, in, 32: current PC from the PC register.
- `ifu_stall`, in, 1: fetch cannot advance this cycle.
- `exc_valid`, in, 1: exception redirect request, single-cycle pulse.
- `eret_valid`, in, 1: eret redirect request, single-cycle pulse.
- `epc`, in, 32: eret target, sampled when `eret_valid` is high.
- `br_valid`, in, 1: branch/jump taken redirect, single-cycle pulse.
- `br_target`, in, 32: branch target, sampled when `br_valid` is high.
- `next_pc`, out, 32: next-PC value to the PC register.
- `pc_stall`, out, 1: stall to the PC register. Equals `ifu_stall`.
- `fetch_flush`, out, 1: squash in-flight fetch; one-cycle pulse.
- `pend_valid`, out, 1: a redirect is currently buffered (status/debug).

The PC register's `flush` input is tied to 0 at integration. All redirects go through `next_pc`.

## Operation
- Priority, highest first: exc (target `EXC_VECTOR`) > eret (`epc`) > branch (`br_target`) > sequential (`pc + 4`).
- Sequential increment is modulo 2^32: `32'hffff_fffc` gives `32'h0000_0000`. Bits [1:0] of targets pass through unmodified; alignment faults are handled elsewhere.
- Internal registers: `pend_valid`, `pend_class` (2 bits: EXC/ERET/BR), `pend_target` (32 bits).
- States:
  - RUN: nothing pending.
  - HOLD: a redirect is buffered.
- RUN:
  - No request: `next_pc = pc + 4`.
  - Winning request and `!ifu_stall`: `next_pc = target`, `fetch_flush = 1`, remain in RUN.
  - Winning request and `ifu_stall`: latch class and target, go to HOLD. `fetch_flush = 1` in this same cycle, so younger fetched words are dropped.
- HOLD:
  - Effective redirect is the higher-priority of the buffered one and any new request. On a class tie, the new request wins.
  - While `ifu_stall`: update the buffer with the effective redirect. `fetch_flush = 1` only in cycles where a new request arrives.
  - When `!ifu_stall`: `next_pc = effective target`, clear the buffer, go to RUN. `fetch_flush = 1` only if a new request arrives in that cycle.
- Simultaneous requests in one cycle: only the highest class is used; the others are discarded.
- Reset, asserted at any time including HOLD: asynchronously clear `pend_valid`, the class, and the target to 0, and enter RUN. Outputs during reset follow RUN with no buffer: `next_pc = pc + 4`, `fetch_flush` follows the request inputs, `pend_valid = 0`.

## Timing
- `next_pc`, `pc_stall`, and `fetch_flush` are combinational from inputs and buffer state. There are zero cycles of latency from a request to `next_pc` when unstalled.
- A redirect buffered during stall is applied on the first cycle with `ifu_stall = 0`. The PC register loads it at that cycle's edge.
- `pend_valid` is registered: it rises the cycle after the buffering edge and falls the cycle after the apply edge.
- Requests are single-cycle pulses. A source never holds a request and expects re-sampling.

## Configuration
- `NPC_PERF_CNT_EN`:
  - Defined: adds output ports `perf_redirects` (32 bits) and `perf_stall_cycles` (32 bits).
    - `perf_redirects` increments once per applied redirect. Buffered-and-overwritten redirects do not count.
    - `perf_stall_cycles` increments every cycle that `ifu_stall = 1`.
    - Both wrap modulo 2^32 and are reset to 0 by `rst`.
  - Undefined: ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Sequential wrap: `pc = 32'hffff_fffc`, no requests → `next_pc = 32'h0`, `fetch_flush = 0`.
- Unstalled branch: `br_valid = 1`, `br_target = 32'hbfc0_0100` → same cycle `next_pc = 32'hbfc0_0100`, `fetch_flush = 1`, `pend_valid` stays 0.
- Stalled branch, 3-cycle stall, then release → `pend_valid = 1` during the stall. First unstalled cycle: `next_pc = br_target`, `fetch_flush = 0`. Next cycle: `pend_valid = 0`.
- HOLD merge: a branch is buffered, then `exc_valid` arrives while still stalled → on release `next_pc = 32'hbfc0_0380`. A later `br_valid` in HOLD does not displace the buffered exception.
- Same-cycle conflict: `exc_valid`, `eret_valid`, and `br_valid` together, unstalled → `next_pc = 32'hbfc0_0380`. With `exc_valid = 0`, `next_pc = epc`.
- Reset mid-HOLD: assert `rst` asynchronously (not edge-aligned) while `pend_valid = 1` → buffer clears immediately. After release, `next_pc = pc + 4`. With `NPC_PERF_CNT_EN` defined, both counters read 0.

Source files
------------

// File: rtl/npc_ctrl_if.sv
// Fetch-side redirect bus between the pipeline (master) and the next-PC sequencer (slave).
interface npc_ctrl_if;
    logic [31:0] pc;
    logic        ifu_stall;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] epc;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] next_pc;
    logic        pc_stall;
    logic        fetch_flush;
    logic        pend_valid;

    modport master (
        output pc, ifu_stall, exc_valid, eret_valid, epc, br_valid, br_target,
        input  next_pc, pc_stall, fetch_flush, pend_valid
    );

    modport slave (
        input  pc, ifu_stall, exc_valid, eret_valid, epc, br_valid, br_target,
        output next_pc, pc_stall, fetch_flush, pend_valid
    );
endinterface

// File: rtl/npc_ctrl.sv
// Next-PC sequencer: arbitrates exc > eret > branch > pc+4 and buffers redirects across ifu stalls.
// Optional NPC_PERF_CNT_EN adds perf_redirects / perf_stall_cycles counters.
module npc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380
) (
    input  logic        clk,
    input  logic        rst,
    npc_ctrl_if.slave   bus
`ifdef NPC_PERF_CNT_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stall_cycles
`endif
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
    // Numeric order of the encoding is the priority order used in the HOLD merge.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_BR   = 2'd1,
        CLS_ERET = 2'd2,
        CLS_EXC  = 2'd3
    } cls_t;

    state_t      state, state_nx;
    cls_t        pend_class, cls_nx;
    logic [31:0] pend_target, tgt_nx;

    cls_t        req_cls;
    logic [31:0] req_tgt;
    logic        req;
    cls_t        eff_cls;
    logic [31:0] eff_tgt;
    logic        applied;

    always_comb begin
        req_cls = CLS_NONE;
        req_tgt = '0;
        if (bus.exc_valid) begin
            req_cls = CLS_EXC;
            req_tgt = EXC_VECTOR;
        end else if (bus.eret_valid) begin
            req_cls = CLS_ERET;
            req_tgt = bus.epc;
        end else if (bus.br_valid) begin
            req_cls = CLS_BR;
            req_tgt = bus.br_target;
        end
    end

    assign req = (req_cls != CLS_NONE);

    // A new request of equal class replaces the buffered one.
    always_comb begin
        eff_cls = pend_class;
        eff_tgt = pend_target;
        if (req && (req_cls >= pend_class)) begin
            eff_cls = req_cls;
            eff_tgt = req_tgt;
        end
    end

    always_comb begin
        state_nx        = state;
        cls_nx          = pend_class;
        tgt_nx          = pend_target;
        bus.next_pc     = bus.pc + 32'd4;
        bus.fetch_flush = req;
        applied         = 1'b0;
        case (state)
            RUN: begin
                if (req) begin
                    if (bus.ifu_stall) begin
                        state_nx = HOLD;
                        cls_nx   = req_cls;
                        tgt_nx   = req_tgt;
                    end else begin
                        bus.next_pc = req_tgt;
                        applied     = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.ifu_stall) begin
                    cls_nx = eff_cls;
                    tgt_nx = eff_tgt;
                end else begin
                    bus.next_pc = eff_tgt;
                    applied     = 1'b1;
                    state_nx    = RUN;
                    cls_nx      = CLS_NONE;
                    tgt_nx      = '0;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pend_class  <= CLS_NONE;
            pend_target <= '0;
        end else begin
            state       <= state_nx;
            pend_class  <= cls_nx;
            pend_target <= tgt_nx;
        end
    end

    assign bus.pc_stall   = bus.ifu_stall;
    assign bus.pend_valid = (state == HOLD);

`ifdef NPC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_redirects    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (applied)
                perf_redirects <= perf_redirects + 32'd1;
            if (bus.ifu_stall)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    logic unused_applied;
    assign unused_applied = applied;
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed bench for npc_ctrl: expectations queued at drive time, popped and asserted after settling.
module tb_npc_ctrl;
    logic clk = 1'b0;
    logic rst;
    npc_ctrl_if bus ();

`ifdef NPC_PERF_CNT_EN
    logic [31:0] perf_redirects, perf_stall_cycles;
`endif

    npc_ctrl #(.EXC_VECTOR(32'hbfc0_0380)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef NPC_PERF_CNT_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] npc;
        logic        flush;
        logic        pend;
        logic        stall;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    localparam logic [31:0] EXC = 32'hbfc0_0380;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle's inputs at the falling edge, queue the expected outputs, then check them.
    task automatic step(input string tag, input logic [31:0] pc, input logic stall,
                        input logic exc, input logic eret, input logic [31:0] epc,
                        input logic br, input logic [31:0] tgt,
                        input logic [31:0] e_npc, input logic e_flush, input logic e_pend);
        exp_t e;
        @(negedge clk);
        bus.pc = pc; bus.ifu_stall = stall;
        bus.exc_valid = exc; bus.eret_valid = eret; bus.epc = epc;
        bus.br_valid = br; bus.br_target = tgt;
        sb.push_back('{tag, e_npc, e_flush, e_pend, stall});
        #2;
        e = sb.pop_front();
        chk({e.tag, ".next_pc"}, bus.next_pc, e.npc);
        chk({e.tag, ".flush"}, {31'd0, bus.fetch_flush}, {31'd0, e.flush});
        chk({e.tag, ".pend"}, {31'd0, bus.pend_valid}, {31'd0, e.pend});
        chk({e.tag, ".pc_stall"}, {31'd0, bus.pc_stall}, {31'd0, e.stall});
    endtask

    initial begin
        rst = 1'b1;
        bus.pc = 32'h100; bus.ifu_stall = 0; bus.exc_valid = 0; bus.eret_valid = 0;
        bus.epc = 0; bus.br_valid = 0; bus.br_target = 0;
        step("rst", 32'h100, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0);
        @(negedge clk); rst = 1'b0;

        step("wrap", 32'hffff_fffc, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        step("br_unstalled", 32'h200, 0, 0, 0, 0, 1, 32'hbfc0_0100, 32'hbfc0_0100, 1, 0);
        step("br_unstalled_after", 32'hbfc0_0100, 0, 0, 0, 0, 0, 0, 32'hbfc0_0104, 0, 0);

        // Stalled branch held across a 3-cycle stall.
        step("sb_req", 32'h1000, 1, 0, 0, 0, 1, 32'h8000_0041, 32'h1004, 1, 0);
        step("sb_hold1", 32'h1000, 1, 0, 0, 0, 0, 0, 32'h1004, 0, 1);
        step("sb_hold2", 32'h1000, 1, 0, 0, 0, 0, 0, 32'h1004, 0, 1);
        step("sb_release", 32'h1000, 0, 0, 0, 0, 0, 0, 32'h8000_0041, 0, 1);
        step("sb_after", 32'h8000_0041, 0, 0, 0, 0, 0, 0, 32'h8000_0045, 0, 0);

        // Exception overrides a buffered branch; a later branch cannot displace it.
        step("mg_br", 32'h2000, 1, 0, 0, 0, 1, 32'h3000, 32'h2004, 1, 0);
        step("mg_exc", 32'h2000, 1, 1, 0, 0, 0, 0, 32'h2004, 1, 1);
        step("mg_br2", 32'h2000, 1, 0, 0, 0, 1, 32'h4000, 32'h2004, 1, 1);
        step("mg_release", 32'h2000, 0, 0, 0, 0, 0, 0, EXC, 0, 1);
        step("mg_after", EXC, 0, 0, 0, 0, 0, 0, EXC + 32'd4, 0, 0);

        // Equal class: the newer eret replaces the buffered one.
        step("tie_e1", 32'h5000, 1, 0, 1, 32'h6000, 0, 0, 32'h5004, 1, 0);
        step("tie_e2", 32'h5000, 1, 0, 1, 32'h7000, 0, 0, 32'h5004, 1, 1);
        step("tie_release", 32'h5000, 0, 0, 0, 0, 0, 0, 32'h7000, 0, 1);

        // Release cycle carrying a new request: higher new wins, lower new loses.
        step("rn_br", 32'h8000, 1, 0, 0, 0, 1, 32'h9000, 32'h8004, 1, 0);
        step("rn_eret", 32'h8000, 0, 0, 1, 32'ha000, 0, 0, 32'ha000, 1, 1);
        step("rl_eret", 32'hb000, 1, 0, 1, 32'hc000, 0, 0, 32'hb004, 1, 0);
        step("rl_br", 32'hb000, 0, 0, 0, 0, 1, 32'hd000, 32'hc000, 1, 1);

        step("cf_all", 32'he000, 0, 1, 1, 32'hf000, 1, 32'hf100, EXC, 1, 0);
        step("cf_no_exc", 32'he000, 0, 0, 1, 32'hf000, 1, 32'hf100, 32'hf000, 1, 0);

        // Asynchronous reset while a redirect is buffered.
        step("rh_br", 32'h1200, 1, 0, 0, 0, 1, 32'h1300, 32'h1204, 1, 0);
        step("rh_hold", 32'h1200, 1, 0, 0, 0, 0, 0, 32'h1204, 0, 1);
        #1 rst = 1'b1;
        #1 chk("rh_async_pend", {31'd0, bus.pend_valid}, 32'd0);
        step("rh_in_rst", 32'h1200, 0, 0, 0, 0, 0, 0, 32'h1204, 0, 0);
        @(negedge clk); rst = 1'b0;
        step("rh_after", 32'h1200, 0, 0, 0, 0, 0, 0, 32'h1204, 0, 0);
`ifdef NPC_PERF_CNT_EN
        chk("perf_redirects_rst", perf_redirects, 32'd0);
        chk("perf_stall_rst", perf_stall_cycles, 32'd0);
`endif

        if (sb.size() != 0) begin
            total++;
            $error("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
